// File: rtl/pwm_ctrl.sv
// PWM controller: register slot, prescaler, phase tracker and per-channel duty registers.
// Define PWM_CTRL_SHADOW_EN to commit duty writes only at period boundaries.
module pwm_ctrl #(
  parameter int W     = 6,
  parameter int PWM_R = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 cs,
  input  logic                 write,
  input  logic                 read,
  input  logic [4:0]           addr,
  input  logic [31:0]          wr_data,
  output logic [31:0]          rd_data,
  output logic                 en_tick,
  output logic [W-1:0]         en,
  output logic [W*PWM_R-1:0]   duty_flat,
  output logic                 period_start
);

  localparam logic [PWM_R-1:0] PH_MAX = '1;
  localparam logic [4:0]       A_DIV  = 5'd0;
  localparam logic [4:0]       A_MASK = 5'd1;
  localparam logic [4:0]       A_STAT = 5'd2;
  localparam int               A_DUTY0 = 8;

  logic [31:0]      div_q, div_d;
  logic [31:0]      cnt_q, cnt_d;
  logic [PWM_R-1:0] phase_q, phase_d;
  logic [W-1:0]     mask_q, mask_d;
  logic             tick_q, tick_d;
  logic             pstart_q, pstart_d;
  logic [PWM_R-1:0] pend_q [W];
  logic [PWM_R-1:0] pend_d [W];
  logic [PWM_R-1:0] act_q  [W];
  logic [PWM_R-1:0] act_d  [W];

  logic wr_en, wr_div, boundary;
  logic unused_ok;

  // Reads are side-effect free, so the strobe carries no information here.
  assign unused_ok = read;

  assign wr_en  = cs & write;
  assign wr_div = wr_en && (addr == A_DIV);
  // A divisor write restarts the timebase, so it also cancels a coincident boundary.
  assign boundary = tick_q && (phase_q == PH_MAX) && !wr_div;

  always_comb begin
    div_d    = div_q;
    mask_d   = mask_q;
    tick_d   = (cnt_q == div_q);
    cnt_d    = (cnt_q == div_q) ? 32'd0 : cnt_q + 32'd1;
    phase_d  = tick_q ? phase_q + PWM_R'(1) : phase_q;
    pstart_d = boundary;
    if (wr_div) begin
      div_d   = wr_data;
      cnt_d   = 32'd0;
      tick_d  = 1'b0;
      phase_d = '0;
    end
    if (wr_en && (addr == A_MASK)) mask_d = wr_data[W-1:0];
    for (int i = 0; i < W; i++) begin
      pend_d[i] = pend_q[i];
      act_d[i]  = act_q[i];
`ifdef PWM_CTRL_SHADOW_EN
      // Commit uses the pre-write pending value; a same-edge write waits a period.
      if (boundary) act_d[i] = pend_q[i];
`endif
      if (wr_en && (int'(addr) == A_DUTY0 + i)) begin
        pend_d[i] = wr_data[PWM_R-1:0];
`ifndef PWM_CTRL_SHADOW_EN
        act_d[i]  = wr_data[PWM_R-1:0];
`endif
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      div_q    <= '0;
      cnt_q    <= '0;
      phase_q  <= '0;
      mask_q   <= '0;
      tick_q   <= 1'b0;
      pstart_q <= 1'b0;
      for (int i = 0; i < W; i++) begin
        pend_q[i] <= '0;
        act_q[i]  <= '0;
      end
    end else begin
      div_q    <= div_d;
      cnt_q    <= cnt_d;
      phase_q  <= phase_d;
      mask_q   <= mask_d;
      tick_q   <= tick_d;
      pstart_q <= pstart_d;
      for (int i = 0; i < W; i++) begin
        pend_q[i] <= pend_d[i];
        act_q[i]  <= act_d[i];
      end
    end
  end

  always_comb begin
    rd_data = '0;
    case (addr)
      A_DIV:   rd_data = div_q;
      A_MASK:  rd_data[W-1:0] = mask_q;
      A_STAT:  rd_data[PWM_R-1:0] = phase_q;
      default: begin
        for (int i = 0; i < W; i++) begin
          if (int'(addr) == A_DUTY0 + i) rd_data[PWM_R-1:0] = pend_q[i];
        end
      end
    endcase
  end

  assign en_tick      = tick_q;
  assign period_start = pstart_q;
  assign en           = mask_q;

  for (genvar g = 0; g < W; g++) begin : g_duty
    assign duty_flat[g*PWM_R +: PWM_R] = act_q[g];
  end

endmodule

// File: doc/pwm_ctrl.md
PWM_CTRL -- requirements
Module: pwm_ctrl

Interface
REQ-001 SHALL have parameter W, default 6, number of PWM channels driven.
REQ-002 SHALL have parameter PWM_R, default 8, duty/phase resolution in bits; it matches the downstream PWM channel resolution.
REQ-003 SHALL have port clk, input, 1, system clock; all state is on its rising edge.
REQ-004 SHALL have port rst, input, 1, asynchronous active-high reset.
REQ-005 SHALL have port cs, input, 1, slot chip select.
REQ-006 SHALL have port write, input, 1, write strobe; valid only with cs.
REQ-007 SHALL have port read, input, 1, read strobe; has no side effects.
REQ-008 SHALL have port addr, input, 5, register word address.
REQ-009 SHALL have port wr_data, input, 32, write data.
REQ-010 SHALL have port rd_data, output, 32, read data.
REQ-011 SHALL have port en_tick, output, 1, registered one-clk prescaler pulse to every channel.
REQ-012 SHALL have port en, output, W, per-channel enable, bit i to channel i.
REQ-013 SHALL have port duty_flat, output, W*PWM_R, active duty; channel i at bits [i*PWM_R +: PWM_R].
REQ-014 SHALL have port period_start, output, 1, registered one-clk pulse on the cycle a new PWM period begins.

Function
REQ-015 SHALL decode the register map as: addr 0 = divisor (RW, 32b); addr 1 = enable mask (RW, low W bits); addr 2 = status (RO: phase in [PWM_R-1:0]); addr 8..8+W-1 = duty channel 0..W-1 (RW, low PWM_R bits).
REQ-016 SHALL apply a write on the rising edge where cs&write=1 and addr is mapped; writes to unmapped or RO addresses are ignored.
REQ-017 SHALL drive rd_data combinationally from addr (zero latency); unused bits and unmapped addresses read 0; duty addresses return the pending (last written) value.
REQ-018 SHALL implement a 32-bit prescaler counter q: when q==divisor, q<=0 and en_tick<=1 on that edge; otherwise q<=q+1 and en_tick<=0.
REQ-019 SHALL pulse en_tick on every clk when divisor=0, giving a tick period of divisor+1 clks.
REQ-020 SHALL, on a divisor write, clear q, clear phase, and force en_tick<=0 on the same edge; the write wins over a coincident tick.
REQ-021 SHALL keep a PWM_R-bit phase counter that mirrors the channel counter: it increments on every en_tick and wraps from 2^PWM_R-1 to 0.
REQ-022 SHALL assert period_start for one clk on the edge after an en_tick at which phase wrapped to 0.
REQ-023 SHALL drive en directly from the enable-mask register, updated on the edge of the write.
REQ-024 SHALL hold duty writes in a per-channel pending register; active duty drives duty_flat.
REQ-025 SHALL commit pending to active on the boundary edge (en_tick with phase==2^PWM_R-1) when shadowing is enabled; see REQ-031.
REQ-026 SHALL, on a duty write coincident with a boundary, commit the pre-write pending value; the new value commits at the next boundary.
REQ-027 SHALL pass duty values unmodified; duty semantics (including 0 and all-ones) belong to the downstream channel.

Reset
REQ-028 SHALL, on rst, immediately clear divisor, q, phase, enable mask, all pending and active duties, en_tick and period_start to 0.
REQ-029 SHALL, on rst asserted mid-period, abandon the period with no pending commit; after release, ticking restarts from q=0 with divisor 0.

Configuration
REQ-030 SHALL use macro PWM_CTRL_SHADOW_EN to select duty update mode.
REQ-031 SHALL, with PWM_CTRL_SHADOW_EN defined, update active duty only at period boundaries per REQ-025/026 (glitch-free).
REQ-032 SHALL, without PWM_CTRL_SHADOW_EN, write active and pending together on the write edge; the register map and all other behaviour are unchanged.

Verification
REQ-033 SHALL cover: reset, write divisor=3 -> en_tick high exactly one clk in every 4, first pulse 4 clks after the write edge.
REQ-034 SHALL cover: divisor=0, 256 clks -> phase reads 0 again, period_start pulses exactly once.
REQ-035 SHALL cover (shadow): duty[2]=0x40 written mid-period -> duty_flat channel 2 unchanged until the boundary edge, then 0x40; rd_data at addr 10 reads 0x40 immediately.
REQ-036 SHALL cover (shadow): duty[0] written 0x10 on the exact boundary edge with pending 0x80 -> active 0x80 now, 0x10 at the following boundary.
REQ-037 SHALL cover: divisor written on an en_tick edge -> no tick that cycle, q and phase read 0, next tick after divisor+1 clks.
REQ-038 SHALL cover: rst pulse mid-period with mask 0x3F, duties 0x55 -> all outputs 0 asynchronously; reads of addr 1 and 8..13 return 0; unmapped addr 31 reads 0.
